cp0_regfile: RTL
================

# cp0_regfile

Coprocessor-0 register file and timer for the dual-issue MIPS32r1 core. Consumes the exception unit's commit outputs (exception entry, ERET, EPC, cause code, bad address, ASID) plus MTC0/MFC0 traffic from the memory stage. Produces the interrupt-enable, pending-interrupt, vector-base and EPC information that the exception unit evaluates in the next cycle. Holds BadVAddr, Count, EntryHi, Compare, Status, Cause, EPC, PRId and EBase.

## Interface
- PRID, 32'h0001_8000, constant returned for PRId (reg 15, sel 0)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- hw_int  in  6  external interrupt lines, level-sensitive, map to Cause.IP[7:2]
- raddr / rsel  in  5 / 3  MFC0 register number / select
- rdata  out  32  MFC0 read data, combinational, pre-write value
- wen  in  1  MTC0 write strobe; waddr / wsel  in  5 / 3; wdata  in  32
- exp_en  in  1  exception entry commit
- exl_clean  in  1  ERET commit
- exp_epc  in  32; exp_code  in  5; exp_bd  in  1
- exp_bad_vaddr  in  32; exp_bad_vaddr_wen  in  1
- exp_asid  in  8; exp_asid_en  in  1
- epc_address  out  32  EPC value, with same-cycle MTC0 EPC bypass
- allow_interrupt  out  1  Status.IE & ~Status.EXL
- interrupt_flag  out  8  Cause.IP & Status.IM
- ebase  out  32  EBase register; use_special_iv  out  1  Cause.IV; use_bootstrap_iv  out  1  Status.BEV
- exl  out  1  Status.EXL; asid  out  8  EntryHi[7:0]

## Operation
- Register map (num,sel): BadVAddr(8,0) read-only to MTC0; Count(9,0); EntryHi(10,0) writable [31:13],[7:0]; Compare(11,0); Status(12,0) writable BEV[22], IM[15:8], EXL[1], IE[0]; Cause(13,0) writable IV[23], IP[9:8] only; EPC(14,0); PRId(15,0) RO; EBase(15,1) writable [29:12], [31:30] fixed 2'b10. Unmapped reads return 0; unmapped writes are ignored.
- Reset values: Status=32'h0040_0000 (BEV=1, EXL=0, IE=0); Cause=0; Count=0; Compare=0; EPC=0; BadVAddr=0; EntryHi=0; EBase=32'h8000_0000; internal tick=0. Outputs follow: allow_interrupt=0, interrupt_flag=0, ebase=32'h8000_0000, use_bootstrap_iv=1, exl=0, asid=0, epc_address=0.
- Timer: tick toggles every cycle; Count increments by 1 when tick=1, wrapping 32'hFFFF_FFFF→0. When Count increments to a value equal to Compare, Cause.TI[30] sets. A write to Compare clears TI. A write to Count loads wdata and clears tick; it takes priority over that cycle's increment.
- Cause.IP[7] = hw_int[5] | TI; IP[6:2] = hw_int[4:0]. Both are registered each cycle. IP[1:0] are software-written.
- Exception entry (exp_en=1): if Status.EXL=0 at the edge, EPC←exp_epc and Cause.BD←exp_bd. If EXL=1, EPC and BD are unchanged. Cause.ExcCode[6:2]←exp_code and Status.EXL←1 unconditionally. If exp_bad_vaddr_wen, BadVAddr←exp_bad_vaddr. If exp_asid_en, EntryHi[7:0]←exp_asid.
- ERET (exl_clean=1, exp_en=0): Status.EXL←0. exp_en wins when both are asserted.
- Same-cycle MTC0 and exception: the exception wins on every field it writes (EXL, ExcCode, BD, EPC, BadVAddr, ASID). The MTC0 still updates all other fields and registers.
- epc_address = (wen && waddr==14 && wsel==0) ? wdata : EPC.

## Timing
- MTC0 and exception effects are visible in rdata and outputs one cycle after the edge.
- hw_int to interrupt_flag latency: 1 cycle.
- Count==Compare to interrupt_flag[7] latency: 1 cycle after the incrementing edge.
- MFC0 in the same cycle as an MTC0 to the same register returns the old value; only epc_address bypasses.
- Reset asserted mid-operation overrides every write in that cycle.

## Test plan
- Reset, then read Status/EBase/PRId → 32'h0040_0000 / 32'h8000_0000 / 32'h0001_8000; use_bootstrap_iv=1, allow_interrupt=0.
- MTC0 Compare=5, Count=0, Status=32'h0000_8001 → TI sets after Count reaches 5 (cycle 10 after write); interrupt_flag=8'h80 one cycle later; MTC0 Compare=100 → TI=0, interrupt_flag=0.
- exp_en with exp_epc=32'hBFC0_0100, exp_code=5'h0c, exp_bd=1 while EXL=0 → EPC=32'hBFC0_0100, Cause[31]=1, Cause[6:2]=5'h0c, exl=1, allow_interrupt=0. Second exp_en with exp_epc=32'h1234 → EPC unchanged, ExcCode updated.
- exl_clean → exl=0. exl_clean with exp_en in the same cycle → exl stays 1.
- MTC0 EPC=32'h8000_1000 with exl_clean in the same cycle → epc_address=32'h8000_1000 that cycle; MFC0 EPC returns the new value next cycle.
- exp_en+exp_asid_en (asid 8'h3A) with MTC0 EntryHi=32'hFFFF_E0FF in the same cycle → EntryHi=32'hFFFF_E03A, asid=8'h3A.

Source files
------------

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file and timer: holds the MIPS32r1 privileged state,
// merges MTC0 traffic with exception/ERET commits and raises timer interrupts.
module cp0_regfile #(
    parameter logic [31:0] PRID = 32'h0001_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic [4:0]  raddr,
    input  logic [2:0]  rsel,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [2:0]  wsel,
    input  logic [31:0] wdata,
    input  logic        exp_en,
    input  logic        exl_clean,
    input  logic [31:0] exp_epc,
    input  logic [4:0]  exp_code,
    input  logic        exp_bd,
    input  logic [31:0] exp_bad_vaddr,
    input  logic        exp_bad_vaddr_wen,
    input  logic [7:0]  exp_asid,
    input  logic        exp_asid_en,
    output logic [31:0] epc_address,
    output logic        allow_interrupt,
    output logic [7:0]  interrupt_flag,
    output logic [31:0] ebase,
    output logic        use_special_iv,
    output logic        use_bootstrap_iv,
    output logic        exl,
    output logic [7:0]  asid
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_ENTRYHI  = 5'd10;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    // Timer state
    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;

    // Status fields
    logic        r_bev;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;

    // Cause fields; r_ip_hw holds IP[7:2], r_ip_sw holds IP[1:0]
    logic        r_bd;
    logic        r_ti;
    logic        r_iv;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exc_code;

    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [18:0] r_vpn;
    logic [7:0]  r_asid;
    logic [17:0] r_ebase_base;

    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_wr_entryhi;
    logic        w_wr_ebase;
    logic [31:0] w_count_inc;
    logic        w_ti_hit;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_entryhi;
    logic [31:0] w_ebase;

    assign w_wr_count   = wen && (waddr == REG_COUNT)   && (wsel == 3'd0);
    assign w_wr_compare = wen && (waddr == REG_COMPARE) && (wsel == 3'd0);
    assign w_wr_status  = wen && (waddr == REG_STATUS)  && (wsel == 3'd0);
    assign w_wr_cause   = wen && (waddr == REG_CAUSE)   && (wsel == 3'd0);
    assign w_wr_epc     = wen && (waddr == REG_EPC)     && (wsel == 3'd0);
    assign w_wr_entryhi = wen && (waddr == REG_ENTRYHI) && (wsel == 3'd0);
    assign w_wr_ebase   = wen && (waddr == REG_PRID)    && (wsel == 3'd1);

    assign w_count_inc = r_count + 32'd1;
    // TI only sets on an actual increment that lands on Compare, never on a load
    assign w_ti_hit    = !w_wr_count && r_tick && (w_count_inc == r_compare);

    assign w_status  = {9'b0, r_bev, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause   = {r_bd, r_ti, 6'b0, r_iv, 7'b0, r_ip_hw, r_ip_sw, 1'b0, r_exc_code, 2'b0};
    assign w_entryhi = {r_vpn, 5'b0, r_asid};
    assign w_ebase   = {2'b10, r_ebase_base, 12'b0};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tick    <= 1'b0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (w_wr_count) begin
                r_count <= wdata;
                r_tick  <= 1'b0;
            end else if (r_tick) begin
                r_count <= w_count_inc;
            end
            if (w_wr_compare) begin
                r_compare <= wdata;
            end
            if (w_wr_compare) begin
                r_ti <= 1'b0;
            end else if (w_ti_hit) begin
                r_ti <= 1'b1;
            end
        end
    end

    // MTC0 updates first; exception/ERET assignments come later so they win
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bev      <= 1'b1;
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_iv       <= 1'b0;
            r_ip_hw    <= 6'd0;
            r_ip_sw    <= 2'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
        end else begin
            r_ip_hw <= {hw_int[5] | r_ti, hw_int[4:0]};
            if (w_wr_status) begin
                r_bev <= wdata[22];
                r_im  <= wdata[15:8];
                r_exl <= wdata[1];
                r_ie  <= wdata[0];
            end
            if (w_wr_cause) begin
                r_iv    <= wdata[23];
                r_ip_sw <= wdata[9:8];
            end
            if (w_wr_epc) begin
                r_epc <= wdata;
            end
            if (exp_en) begin
                if (!r_exl) begin
                    r_epc <= exp_epc;
                    r_bd  <= exp_bd;
                end
                r_exc_code <= exp_code;
                r_exl      <= 1'b1;
                if (exp_bad_vaddr_wen) begin
                    r_badvaddr <= exp_bad_vaddr;
                end
            end else if (exl_clean) begin
                r_exl <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vpn        <= 19'd0;
            r_asid       <= 8'd0;
            r_ebase_base <= 18'd0;
        end else begin
            if (w_wr_entryhi) begin
                r_vpn  <= wdata[31:13];
                r_asid <= wdata[7:0];
            end
            if (exp_en && exp_asid_en) begin
                r_asid <= exp_asid;
            end
            if (w_wr_ebase) begin
                r_ebase_base <= wdata[29:12];
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (rsel == 3'd0) begin
            case (raddr)
                REG_BADVADDR: rdata = r_badvaddr;
                REG_COUNT:    rdata = r_count;
                REG_ENTRYHI:  rdata = w_entryhi;
                REG_COMPARE:  rdata = r_compare;
                REG_STATUS:   rdata = w_status;
                REG_CAUSE:    rdata = w_cause;
                REG_EPC:      rdata = r_epc;
                REG_PRID:     rdata = PRID;
                default:      rdata = 32'd0;
            endcase
        end else if ((rsel == 3'd1) && (raddr == REG_PRID)) begin
            rdata = w_ebase;
        end
    end

    assign epc_address      = w_wr_epc ? wdata : r_epc;
    assign allow_interrupt  = r_ie & ~r_exl;
    assign interrupt_flag   = w_cause[15:8] & r_im;
    assign ebase            = w_ebase;
    assign use_special_iv   = r_iv;
    assign use_bootstrap_iv = r_bev;
    assign exl              = r_exl;
    assign asid             = r_asid;

endmodule
